// File: rtl/pcs_pkg.sv
// Shared 1000BASE-T PCS definitions: PAM5 symbols, delimiters, receive FSM states,
// GMII codes, descrambler polynomials and the data byte <-> quartet mapping.
package pcs_pkg;

  typedef logic [2:0] pam5_t;

  localparam pam5_t PAM5_M2 = 3'b110;
  localparam pam5_t PAM5_M1 = 3'b111;
  localparam pam5_t PAM5_0  = 3'b000;
  localparam pam5_t PAM5_P1 = 3'b001;
  localparam pam5_t PAM5_P2 = 3'b010;

  typedef struct packed {
    pam5_t a;
    pam5_t b;
    pam5_t c;
    pam5_t d;
  } quartet_t;

  localparam quartet_t SSD1 = '{PAM5_P2, PAM5_P2, PAM5_P2, PAM5_P2};
  localparam quartet_t SSD2 = '{PAM5_P2, PAM5_P2, PAM5_P2, PAM5_M2};
  localparam quartet_t ESD1 = '{PAM5_P2, PAM5_P2, PAM5_P2, PAM5_P2};
  localparam quartet_t ESD2 = '{PAM5_P2, PAM5_P2, PAM5_P2, PAM5_M2};

  typedef enum logic [1:0] {
    RX_IDLE      = 2'd0,
    RX_SSD2_WAIT = 2'd1,
    RX_DATA      = 2'd2,
    RX_ESD2_WAIT = 2'd3
  } rx_state_t;

  localparam logic [7:0] GMII_FALSE_CARRIER = 8'h0E;
  localparam logic [7:0] GMII_PREAMBLE      = 8'h55;

  // Middle tap exponents of x^33+x^13+1 (master) and x^33+x^20+1 (slave).
  localparam int unsigned POLY_MASTER_TAP = 13;
  localparam int unsigned POLY_SLAVE_TAP  = 20;

  function automatic logic is_invalid_sym(input pam5_t s);
    return (s == 3'b011) || (s == 3'b100) || (s == 3'b101);
  endfunction

  function automatic logic is_odd_sym(input pam5_t s);
    return (s == PAM5_P1) || (s == PAM5_M1);
  endfunction

  // Each data symbol carries two bits and is never +2, so no data quartet is all-+2.
  function automatic logic [1:0] sym_to_bits(input pam5_t s);
    case (s)
      PAM5_P1: return 2'b01;
      PAM5_M1: return 2'b10;
      PAM5_M2: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic pam5_t bits_to_sym(input logic [1:0] v);
    case (v)
      2'b00:   return PAM5_0;
      2'b01:   return PAM5_P1;
      2'b10:   return PAM5_M1;
      default: return PAM5_M2;
    endcase
  endfunction

  function automatic logic [7:0] sd_from_quartet(input pam5_t a, input pam5_t b,
                                                 input pam5_t c, input pam5_t d);
    return {sym_to_bits(d), sym_to_bits(c), sym_to_bits(b), sym_to_bits(a)};
  endfunction

  function automatic quartet_t quartet_from_sd(input logic [7:0] sd);
    return '{bits_to_sym(sd[1:0]), bits_to_sym(sd[3:2]),
             bits_to_sym(sd[5:4]), bits_to_sym(sd[7:6])};
  endfunction

endpackage

// File: rtl/pcs_rx_decoder_descrambler.sv
// Side-stream descrambler: Fibonacci LFSR, all-ones on clear, one step per advance.
module rx_descrambler
  import pcs_pkg::*;
#(
  parameter int LFSR_W = 33
) (
  input  logic       clock,
  input  logic       i_clear,
  input  logic       i_advance,
  input  logic       i_master,
  output logic [7:0] o_sc
);

  localparam int MASTER_IDX = int'(POLY_MASTER_TAP) - 1;
  localparam int SLAVE_IDX  = int'(POLY_SLAVE_TAP) - 1;

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  // Polynomial select is looked at on every step, so it may change between quartets.
  assign w_fb = r_lfsr[LFSR_W-1] ^ (i_master ? r_lfsr[MASTER_IDX] : r_lfsr[SLAVE_IDX]);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (i_clear) begin
      r_lfsr <= '1;
    end else if (i_advance) begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
    end
  end

  assign o_sc = r_lfsr[7:0];

endmodule

// File: rtl/pcs_rx_decoder.sv
// 1000BASE-T receive PCS: delimiter detection, data demap/descramble and GMII-style
// registered outputs, with a sticky receive error flag.
module pcs_rx_decoder
  import pcs_pkg::*;
#(
  parameter int LFSR_W = 33
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_pcs_reset,
  input  logic       io_config_master,
  input  logic       io_loc_rcvr_status,
  input  logic       io_rx_symb_vector_valid,
  output logic       io_rx_symb_vector_ready,
  input  logic [2:0] io_rx_symb_vector_bits_0,
  input  logic [2:0] io_rx_symb_vector_bits_1,
  input  logic [2:0] io_rx_symb_vector_bits_2,
  input  logic [2:0] io_rx_symb_vector_bits_3,
  output logic [7:0] io_rxd,
  output logic       io_rx_dv,
  output logic       io_rx_er,
  output logic       io_rxerror_status
);

  localparam logic [1:0] ST_IDLE      = RX_IDLE;
  localparam logic [1:0] ST_SSD2_WAIT = RX_SSD2_WAIT;
  localparam logic [1:0] ST_DATA      = RX_DATA;
  localparam logic [1:0] ST_ESD2_WAIT = RX_ESD2_WAIT;

  logic [1:0] r_state;
  logic [7:0] r_rxd;
  logic       r_dv;
  logic       r_er;
  logic       r_status;

  logic       w_clear;
  logic       w_accept;
  quartet_t   w_q;
  logic       w_any_invalid;
  logic       w_any_odd;
  logic [7:0] w_sc;
  logic [7:0] w_data;
  logic [1:0] w_state_nxt;
  logic [7:0] w_rxd_nxt;
  logic       w_dv_nxt;
  logic       w_er_nxt;
  logic       w_status_nxt;

  assign w_clear  = reset | io_pcs_reset;
  assign io_rx_symb_vector_ready = !reset && !io_pcs_reset && io_loc_rcvr_status;
  assign w_accept = io_rx_symb_vector_valid & io_rx_symb_vector_ready;

  assign w_q = '{io_rx_symb_vector_bits_0, io_rx_symb_vector_bits_1,
                 io_rx_symb_vector_bits_2, io_rx_symb_vector_bits_3};

  assign w_any_invalid = is_invalid_sym(w_q.a) | is_invalid_sym(w_q.b) |
                         is_invalid_sym(w_q.c) | is_invalid_sym(w_q.d);
  assign w_any_odd     = is_odd_sym(w_q.a) | is_odd_sym(w_q.b) |
                         is_odd_sym(w_q.c) | is_odd_sym(w_q.d);

  rx_descrambler #(.LFSR_W(LFSR_W)) u_descrambler (
    .clock     (clock),
    .i_clear   (w_clear),
    .i_advance (w_accept),
    .i_master  (io_config_master),
    .o_sc      (w_sc)
  );

  assign w_data = sd_from_quartet(w_q.a, w_q.b, w_q.c, w_q.d) ^ w_sc;

  // NOTE: every next-state signal gets a hold default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_rxd_nxt    = r_rxd;
    w_dv_nxt     = r_dv;
    w_er_nxt     = r_er;
    w_status_nxt = r_status;
    if (!io_loc_rcvr_status) begin
      w_state_nxt  = ST_IDLE;
      w_rxd_nxt    = 8'h00;
      w_dv_nxt     = 1'b0;
      w_er_nxt     = 1'b0;
      w_status_nxt = 1'b1;
    end else if (w_accept) begin
      w_rxd_nxt = 8'h00;
      w_dv_nxt  = 1'b0;
      w_er_nxt  = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_q == SSD1) begin
            w_state_nxt = ST_SSD2_WAIT;
          end else if (w_any_odd || w_any_invalid) begin
            w_er_nxt  = 1'b1;
            w_rxd_nxt = GMII_FALSE_CARRIER;
          end
        end
        ST_SSD2_WAIT: begin
          if (w_q == SSD2) begin
            w_state_nxt = ST_DATA;
            w_rxd_nxt   = GMII_PREAMBLE;
            w_dv_nxt    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_er_nxt    = 1'b1;
            w_rxd_nxt   = GMII_FALSE_CARRIER;
          end
        end
        ST_DATA: begin
          if (w_q == ESD1) begin
            w_state_nxt = ST_ESD2_WAIT;
          end else if (w_any_invalid) begin
            w_dv_nxt     = 1'b1;
            w_er_nxt     = 1'b1;
            w_status_nxt = 1'b1;
          end else begin
            w_dv_nxt  = 1'b1;
            w_rxd_nxt = w_data;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          if (w_q != ESD2) begin
            w_er_nxt     = 1'b1;
            w_status_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_state  <= ST_IDLE;
      r_rxd    <= 8'h00;
      r_dv     <= 1'b0;
      r_er     <= 1'b0;
      r_status <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rxd    <= w_rxd_nxt;
      r_dv     <= w_dv_nxt;
      r_er     <= w_er_nxt;
      r_status <= w_status_nxt;
    end
  end

  assign io_rxd            = r_rxd;
  assign io_rx_dv          = r_dv;
  assign io_rx_er          = r_er;
  assign io_rxerror_status = r_status;

endmodule
